// File: rtl/mips_dmem_mmio.sv
// Data-side memory responder: word-addressed RAM with asynchronous read plus a
// memory-mapped window holding GPIO and a compare timer with a level interrupt.
module mips_dmem_mmio #(
  parameter int                       DATA_MEM_WIDTH = 32,
  parameter int                       DEPTH          = 256,
  parameter logic [DATA_MEM_WIDTH-1:0] MMIO_BASE     = 32'hFFFF_0000,
  parameter int                       GPIO_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  input  logic [GPIO_WIDTH-1:0]     gpio_in,
  output logic [GPIO_WIDTH-1:0]     gpio_out,
  output logic                      irq
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_MEM_WIDTH-1:0] r_mem [DEPTH];
  logic [GPIO_WIDTH-1:0]     r_gpio_out;
  logic [GPIO_WIDTH-1:0]     r_sync1;
  logic [GPIO_WIDTH-1:0]     r_sync2;
  logic [DATA_MEM_WIDTH-1:0] r_count;
  logic [DATA_MEM_WIDTH-1:0] r_cmp;
  logic [2:0]                r_ctrl;
  logic                      r_match;

  logic          w_hit;
  logic [5:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_mmio_wr;
  logic          w_wr_gpio;
  logic          w_wr_count;
  logic          w_wr_cmp;
  logic          w_wr_ctrl;
  logic          w_wr_stat;
  logic          w_match;

  assign w_hit      = (memaddr[31:16] == MMIO_BASE[31:16]);
  assign w_off      = memaddr[7:2];
  assign w_idx      = memaddr[AW+1:2];
  assign w_mmio_wr  = memwrite && w_hit;
  assign w_wr_gpio  = w_mmio_wr && (w_off == 6'd0);
  assign w_wr_count = w_mmio_wr && (w_off == 6'd2);
  assign w_wr_cmp   = w_mmio_wr && (w_off == 6'd3);
  assign w_wr_ctrl  = w_mmio_wr && (w_off == 6'd4);
  assign w_wr_stat  = w_mmio_wr && (w_off == 6'd5);

  // Match uses the pre-write COUNT/CMP and is only detected while counting.
  assign w_match = r_ctrl[0] && (r_count == r_cmp);
  assign irq     = r_match && r_ctrl[2];
  assign gpio_out = r_gpio_out;

  // RAM contents are never cleared; writes are simply suppressed during reset.
  always_ff @(posedge clk) begin
    if (rst_n && memwrite && !w_hit) begin
      r_mem[w_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_cmp      <= '0;
      r_ctrl     <= '0;
      r_match    <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_wr_gpio) r_gpio_out <= writedata[GPIO_WIDTH-1:0];
      if (w_wr_cmp)  r_cmp      <= writedata;
      if (w_wr_ctrl) r_ctrl     <= writedata[2:0];
      if (w_wr_count) begin
        r_count <= writedata;
      end else if (r_ctrl[0]) begin
        r_count <= (w_match && r_ctrl[1]) ? '0 : r_count + DATA_MEM_WIDTH'(1);
      end
      // A hardware match on the same edge wins over a write-1-clear.
      if (w_match) begin
        r_match <= 1'b1;
      end else if (w_wr_stat && writedata[0]) begin
        r_match <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (!w_hit) begin
      readdata = r_mem[w_idx];
    end else begin
      case (w_off)
        6'd0:    readdata = DATA_MEM_WIDTH'(r_gpio_out);
        6'd1:    readdata = DATA_MEM_WIDTH'(r_sync2);
        6'd2:    readdata = r_count;
        6'd3:    readdata = r_cmp;
        6'd4:    readdata = DATA_MEM_WIDTH'(r_ctrl);
        6'd5:    readdata = DATA_MEM_WIDTH'(r_match);
        default: readdata = '0;
      endcase
    end
  end
endmodule
